// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-detected pending bits, per-source mask,
// global enable, and a single req/ack + software-EOI request to the CPU.
module interrupt_controller #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id
);

  // Bus handshake: a register access happens on any rising edge with MemWrite=1
  // (writes) or combinationally while MemRead=1 (reads); irq_req stays high
  // until the CPU returns a one-cycle irq_ack, and the source remains in service
  // until software writes STATUS (EOI).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;
  logic             gen_q, gen_d;
  logic             irq_req_q, irq_req_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic             wr_pending, wr_mask, wr_status, wr_gctrl;
  logic [N_SRC-1:0] rises;
  logic [N_SRC-1:0] ack_clr;
  logic [ID_W-1:0]  cand_id;
  logic             any;

  assign wr_pending = MemWrite && (address == 2'd0);
  assign wr_mask    = MemWrite && (address == 2'd1);
  assign wr_status  = MemWrite && (address == 2'd2);
  assign wr_gctrl   = MemWrite && (address == 2'd3);
  assign rises      = irq_src & ~src_prev_q;

  // Scan downwards so the lowest enabled index is the one left standing.
  always_comb begin
    cand_id = '0;
    any     = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_q[i] && mask_q[i]) begin
        cand_id = ID_W'(i);
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_req_d = irq_req_q;
    irq_id_d  = irq_id_q;
    ack_clr   = '0;
    case (state_q)
      IDLE: begin
        if (gen_q && any) begin
          state_d   = REQ;
          irq_req_d = 1'b1;
          irq_id_d  = cand_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d   = SERVICE;
          irq_req_d = 1'b0;
          ack_clr   = N_SRC'(1) << irq_id_q;
        end
      end
      SERVICE: begin
        if (wr_status) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        irq_req_d = 1'b0;
      end
    endcase
  end

  // A new edge beats a software W1C, but the acknowledge clear beats the edge.
  always_comb begin
    pending_d = pending_q;
    if (wr_pending) pending_d = pending_d & ~write_data[N_SRC-1:0];
    pending_d = (pending_d | rises) & ~ack_clr;
  end

  always_comb begin
    mask_d     = wr_mask ? write_data[N_SRC-1:0] : mask_q;
    gen_d      = wr_gctrl ? write_data[0] : gen_q;
    src_prev_d = irq_src;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      src_prev_q <= '0;
      gen_q      <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= src_prev_d;
      gen_q      <= gen_d;
      irq_req_q  <= irq_req_d;
      irq_id_q   <= irq_id_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (MemRead) begin
      case (address)
        2'd0:    read_data = 32'(pending_q);
        2'd1:    read_data = 32'(mask_q);
        2'd2:    read_data = 32'({state_q, irq_id_q});
        default: read_data = {31'b0, gen_q};
      endcase
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a behavioural model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_interrupt_controller;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             MemRead = 1'b0;
  logic             MemWrite = 1'b0;
  logic [1:0]       address = '0;
  logic [31:0]      write_data = '0;
  logic [31:0]      read_data;
  logic [N_SRC-1:0] irq_src = '0;
  logic             irq_ack = 1'b0;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .irq_src    (irq_src),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_id     (irq_id)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // State is an int (0 idle, 1 requesting, 2 in service).
  int         m_state;
  logic [7:0] m_pending, m_mask, m_prev;
  logic       m_gen, m_req;
  int         m_id;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_pending = 0; m_mask = 0; m_prev = 0;
      m_gen = 0; m_req = 0; m_id = 0;
    end else begin
      logic [7:0] nxt_pending;
      int cand;
      cand = -1;
      for (int i = 0; i < N_SRC; i++) begin
        if (m_pending[i] && m_mask[i]) begin
          cand = i;
          break;
        end
      end
      nxt_pending = m_pending;
      if (MemWrite && address == 2'd0) nxt_pending = nxt_pending & ~write_data[7:0];
      nxt_pending = nxt_pending | (irq_src & ~m_prev);
      if (m_state == 0) begin
        if (m_gen && cand >= 0) begin
          m_state = 1; m_req = 1; m_id = cand;
        end
      end else if (m_state == 1) begin
        if (irq_ack) begin
          m_state = 2; m_req = 0; nxt_pending[m_id] = 1'b0;
        end
      end else begin
        if (MemWrite && address == 2'd2) m_state = 0;
      end
      m_pending = nxt_pending;
      if (MemWrite && address == 2'd1) m_mask = write_data[7:0];
      if (MemWrite && address == 2'd3) m_gen = write_data[0];
      m_prev = irq_src;
    end
  end

  function automatic logic [31:0] model_read(input logic rd, input logic [1:0] a);
    if (!rd) return 32'h0;
    case (a)
      2'd0:    return {24'h0, m_pending};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return 32'(m_state * 8 + m_id);
      default: return {31'h0, m_gen};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("model_irq_req", {31'h0, irq_req}, {31'h0, m_req});
      check("model_irq_id", 32'(irq_id), 32'(m_id));
      check("model_read_data", read_data, model_read(MemRead, address));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    MemWrite = 1'b1; address = a; write_data = d;
    tick();
    MemWrite = 1'b0; write_data = '0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    MemRead = 1'b1; address = a;
    #1;
    check(name, read_data, exp);
    MemRead = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic req, input logic [ID_W-1:0] id);
    check({name, "_req"}, {31'h0, irq_req}, {31'h0, req});
    check({name, "_id"}, 32'(irq_id), 32'(id));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #12 reset = 1'b1;
    tick();
    expect_out("reset", 1'b0, 3'd0);
    expect_read("reset_pending", 2'd0, 32'h0);
    expect_read("reset_mask", 2'd1, 32'h0);
    expect_read("reset_status", 2'd2, 32'h0);
    expect_read("reset_gctrl", 2'd3, 32'h0);

    // Basic flow on the timer source
    bus_write(2'd1, 32'h01);
    bus_write(2'd3, 32'h1);
    expect_read("gctrl_on", 2'd3, 32'h1);
    irq_src = 8'h01;
    tick();
    expect_out("basic_t", 1'b0, 3'd0);
    expect_read("basic_pending", 2'd0, 32'h01);
    tick();
    expect_out("basic_t1", 1'b1, 3'd0);
    expect_read("basic_status_req", 2'd2, 32'h08);
    ack_pulse();
    expect_out("basic_ack", 1'b0, 3'd0);
    expect_read("basic_pending_ack", 2'd0, 32'h00);
    expect_read("basic_status_svc", 2'd2, 32'h10);
    bus_write(2'd2, 32'h0);
    expect_read("basic_status_eoi", 2'd2, 32'h00);
    irq_src = 8'h00;
    tick();

    // Priority: sources 5 and 2 together
    bus_write(2'd1, 32'hFF);
    irq_src = 8'h24;
    tick();
    expect_read("prio_pending", 2'd0, 32'h24);
    tick();
    expect_out("prio_first", 1'b1, 3'd2);
    ack_pulse();
    expect_read("prio_status_svc", 2'd2, 32'h12);
    expect_read("prio_pending_ack", 2'd0, 32'h20);
    bus_write(2'd2, 32'h0);
    expect_out("prio_eoi", 1'b0, 3'd2);
    tick();
    expect_out("prio_second", 1'b1, 3'd5);
    ack_pulse();
    bus_write(2'd2, 32'h0);
    irq_src = 8'h00;
    tick();

    // Masking
    bus_write(2'd1, 32'h00);
    irq_src = 8'h08;
    tick();
    tick();
    expect_out("mask_off", 1'b0, 3'd5);
    expect_read("mask_pending", 2'd0, 32'h08);
    bus_write(2'd1, 32'h08);
    expect_out("mask_wr", 1'b0, 3'd5);
    tick();
    expect_out("mask_on", 1'b1, 3'd3);
    bus_write(2'd1, 32'h00);
    expect_out("mask_clr_in_req", 1'b1, 3'd3);
    tick();
    expect_out("mask_clr_hold", 1'b1, 3'd3);
    ack_pulse();
    bus_write(2'd2, 32'h0);
    irq_src = 8'h00;
    tick();

    // W1C / edge collision on source 2
    irq_src = 8'h04;
    bus_write(2'd0, 32'h04);
    expect_read("coll_set_wins", 2'd0, 32'h04);
    bus_write(2'd0, 32'hFFFF_FF04);
    expect_read("coll_cleared", 2'd0, 32'h00);
    tick();
    expect_read("coll_level_no_reset", 2'd0, 32'h00);
    irq_src = 8'h00;
    tick();

    // Asynchronous reset while requesting
    bus_write(2'd1, 32'h01);
    irq_src = 8'h01;
    tick();
    tick();
    expect_out("pre_async_reset", 1'b1, 3'd0);
    #1 reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 3'd0);
    irq_src = 8'h00;
    tick();
    reset = 1'b1;
    expect_read("async_reset_mask", 2'd1, 32'h0);
    tick();

    // Ignored handshakes in IDLE, then no nesting in SERVICE
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h1);
    ack_pulse();
    expect_out("stray_ack", 1'b0, 3'd0);
    bus_write(2'd2, 32'h0);
    expect_read("stray_eoi_status", 2'd2, 32'h00);
    irq_src = 8'h02;
    tick();
    tick();
    expect_out("nest_req", 1'b1, 3'd1);
    ack_pulse();
    expect_read("nest_status_svc", 2'd2, 32'h11);
    irq_src = 8'h03;
    tick();
    tick();
    expect_out("nest_blocked", 1'b0, 3'd1);
    expect_read("nest_pending", 2'd0, 32'h01);
    ack_pulse();
    expect_read("nest_stray_ack", 2'd2, 32'h11);
    bus_write(2'd2, 32'h0);
    tick();
    expect_out("nest_after_eoi", 1'b1, 3'd0);
    ack_pulse();
    bus_write(2'd2, 32'h0);
    irq_src = 8'h00;
    tick();

    // Global enable off keeps requests back while pending
    bus_write(2'd3, 32'h0);
    irq_src = 8'h80;
    tick();
    tick();
    expect_out("gen_off", 1'b0, 3'd0);
    expect_read("gen_off_pending", 2'd0, 32'h80);
    bus_write(2'd3, 32'h1);
    tick();
    expect_out("gen_on", 1'b1, 3'd7);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
